// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking arbiter sharing one FIFO write port.
// Every FIFO entry is tagged with the source requester ID in its upper bits.
//
// Ports:
//   clk_i               single clock, all state on posedge
//   resetn_i            synchronous active-low reset
//   req_valid_i         per-requester beat valid
//   req_last_i          per-requester last beat of burst (qualified by valid)
//   req_data_i          requester i payload at [i*DATAWIDTH +: DATAWIDTH]
//   req_ready_o         per-requester beat accept (only the granted bit can be set)
//   fifo_full_i         FIFO full, blocks writes in the same cycle
//   fifo_wr_o           FIFO write strobe
//   fifo_data_in_o      {grant_id, payload}, zero when no write
//   grant_id_o          currently / most recently granted requester
//   busy_o              high while a burst is granted
//   burst_truncated_o   one-cycle pulse after a burst is cut at MAX_BURST beats
//   stall_count_o       saturating count of cycles the granted beat was blocked by full
module fifo_wr_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int IDW       = $clog2(NUM_REQ),
    parameter int MAX_BURST = 16
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    input  logic [NUM_REQ*DATAWIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic                         fifo_full_i,
    output logic                         fifo_wr_o,
    output logic [IDW+DATAWIDTH-1:0]     fifo_data_in_o,
    output logic [IDW-1:0]               grant_id_o,
    output logic                         busy_o,
    output logic                         burst_truncated_o,
    output logic [15:0]                  stall_count_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q,  last_d;
    logic [7:0]     beat_q,  beat_d;
    logic           trunc_q, trunc_d;
    logic [15:0]    stall_q, stall_d;

    logic [DATAWIDTH-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data_i[i*DATAWIDTH +: DATAWIDTH];
    end

    // Round-robin pick: walk upward from last_q+1 with an explicit wrap
    // compare so non-power-of-two NUM_REQ never indexes past the last requester.
    logic           pick_vld;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] cand;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = last_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand == IDW'(NUM_REQ - 1)) begin
                cand = '0;
            end else begin
                cand = cand + IDW'(1);
            end
            if (!pick_vld && req_valid_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Burst datapath; reset gates everything so a burst abandoned by reset
    // cannot emit a partial write in the reset cycle.
    logic       in_burst;
    logic       g_valid;
    logic       g_last;
    logic       xfer;
    logic       end_last;
    logic       end_max;
    logic [7:0] beat_inc;

    assign in_burst = (state_q == BURST) && resetn_i;
    assign g_valid  = req_valid_i[grant_q];
    assign g_last   = req_last_i[grant_q];
    assign xfer     = in_burst && g_valid && !fifo_full_i;
    assign beat_inc = beat_q + 8'd1;
    assign end_last = xfer && g_last;
    // A last beat landing exactly on MAX_BURST is a normal end, not a truncation.
    assign end_max  = xfer && !g_last && (beat_inc == 8'(MAX_BURST));

    always_comb begin
        req_ready_o = '0;
        if (in_burst && !fifo_full_i) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

    assign fifo_wr_o      = xfer;
    assign fifo_data_in_o = xfer ? {grant_q, data_arr[grant_q]} : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        trunc_d = 1'b0;
        stall_d = stall_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BURST;
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (g_valid && fifo_full_i && (stall_q != 16'hFFFF)) begin
                    stall_d = stall_q + 16'd1;
                end
                if (xfer) begin
                    beat_d = beat_inc;
                end
                if (end_last || end_max) begin
                    state_d = IDLE;
                end
                trunc_d = end_max;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            beat_q  <= '0;
            trunc_q <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            trunc_q <= trunc_d;
            stall_q <= stall_d;
        end
    end

    assign grant_id_o        = grant_q;
    assign busy_o            = (state_q == BURST);
    assign burst_truncated_o = trunc_q;
    assign stall_count_o     = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model, on two instances (MAX_BURST 16 and 4).
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            resetn = 1'b0;
    logic [N-1:0]    vld    = '0;
    logic [N-1:0]    lst    = '0;
    logic [N*DW-1:0] dat    = '0;
    logic            full   = 1'b0;

    logic [N-1:0]      rdy_a, rdy_b;
    logic              wr_a, wr_b;
    logic [IDW+DW-1:0] din_a, din_b;
    logic [IDW-1:0]    gid_a, gid_b;
    logic              busy_a, busy_b;
    logic              trc_a, trc_b;
    logic [15:0]       stl_a, stl_b;

    fifo_wr_arbiter #(.DATAWIDTH(DW), .NUM_REQ(N), .MAX_BURST(16)) dut_a (
        .clk_i(clk), .resetn_i(resetn),
        .req_valid_i(vld), .req_last_i(lst), .req_data_i(dat),
        .req_ready_o(rdy_a), .fifo_full_i(full),
        .fifo_wr_o(wr_a), .fifo_data_in_o(din_a),
        .grant_id_o(gid_a), .busy_o(busy_a),
        .burst_truncated_o(trc_a), .stall_count_o(stl_a)
    );

    fifo_wr_arbiter #(.DATAWIDTH(DW), .NUM_REQ(N), .MAX_BURST(4)) dut_b (
        .clk_i(clk), .resetn_i(resetn),
        .req_valid_i(vld), .req_last_i(lst), .req_data_i(dat),
        .req_ready_o(rdy_b), .fifo_full_i(full),
        .fifo_wr_o(wr_b), .fifo_data_in_o(din_b),
        .grant_id_o(gid_b), .busy_o(busy_b),
        .burst_truncated_o(trc_b), .stall_count_o(stl_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- write / pulse logger ----------------
    int                cyc_i = 0;
    logic [IDW+DW-1:0] wqa[$], wqb[$];
    int                wca[$], wcb[$], tca[$], tcb[$];
    int                wfa = 0, wfb = 0;

    always @(negedge clk) begin
        if (wr_a) begin
            wqa.push_back(din_a);
            wca.push_back(cyc_i);
            if (full) wfa++;
        end
        if (wr_b) begin
            wqb.push_back(din_b);
            wcb.push_back(cyc_i);
            if (full) wfb++;
        end
        if (trc_a) tca.push_back(cyc_i);
        if (trc_b) tcb.push_back(cyc_i);
    end

    // ---------------- behavioural reference model ----------------
    // cur = -1 means no grant held; otherwise the requester owning the port.
    int m_cur[2]   = '{-1, -1};
    int m_gid[2]   = '{0, 0};
    int m_last[2]  = '{N-1, N-1};
    int m_beats[2] = '{0, 0};
    int m_stall[2] = '{0, 0};
    bit m_trunc[2] = '{1'b0, 1'b0};
    int mb[2]      = '{16, 4};

    always @(posedge clk) begin
        int  j;
        int  g;
        bit  found;
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                m_cur[k] = -1; m_gid[k] = 0; m_last[k] = N-1;
                m_beats[k] = 0; m_trunc[k] = 1'b0; m_stall[k] = 0;
            end else begin
                m_trunc[k] = 1'b0;
                if (m_cur[k] < 0) begin
                    found = 1'b0;
                    for (int s = 1; s <= N; s++) begin
                        j = (m_last[k] + s) % N;
                        if (!found && vld[j]) begin
                            found = 1'b1;
                            m_cur[k] = j; m_gid[k] = j; m_last[k] = j;
                            m_beats[k] = 0;
                        end
                    end
                end else begin
                    g = m_cur[k];
                    if (vld[g] && full && m_stall[k] < 65535) m_stall[k]++;
                    if (vld[g] && !full) begin
                        m_beats[k]++;
                        if (lst[g]) begin
                            m_cur[k] = -1;
                        end else if (m_beats[k] == mb[k]) begin
                            m_cur[k] = -1;
                            m_trunc[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- producers ----------------
    // Each entry is {last, data}; a beat pops when valid & ready.
    logic [8:0] pq [N][$];

    task automatic do_reset();
        resetn = 1'b0; vld = '0; lst = '0; dat = '0; full = 1'b0;
        for (int i = 0; i < N; i++) pq[i].delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        wqa.delete(); wqb.delete(); wca.delete(); wcb.delete();
        tca.delete(); tcb.delete();
        wfa = 0; wfb = 0;
    endtask

    task automatic run(input int n, input logic [63:0] fm,
                       input logic [63:0] rm, input logic [63:0] mute0,
                       input bit use_b);
        logic [N-1:0] rs;
        for (int c = 0; c < n; c++) begin
            cyc_i  = c;
            resetn = ~rm[c];
            full   = fm[c];
            for (int i = 0; i < N; i++) begin
                vld[i] = (pq[i].size() > 0) && !(i == 0 && mute0[c]);
                lst[i] = vld[i] ? pq[i][0][8] : 1'b0;
                dat[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0][7:0] : 8'h00;
            end
            @(negedge clk);
            rs = use_b ? rdy_b : rdy_a;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (vld[i] && rs[i]) void'(pq[i].pop_front());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0; vld = '1; lst = '0; dat = 32'hA5C3_1234; full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks += 5;
            if ({wr_a, wr_b} !== 2'b00) begin
                n_errors++; $display("FAIL reset_wr got %b want 00", {wr_a, wr_b});
            end
            if ({rdy_a, rdy_b} !== 8'h00) begin
                n_errors++; $display("FAIL reset_ready got %h want 00", {rdy_a, rdy_b});
            end
            if ({gid_a, gid_b} !== 4'h0) begin
                n_errors++; $display("FAIL reset_grant got %h want 0", {gid_a, gid_b});
            end
            if ({stl_a, stl_b} !== 32'h0) begin
                n_errors++; $display("FAIL reset_stall got %h want 0", {stl_a, stl_b});
            end
            if ({busy_a, busy_b, trc_a, trc_b} !== 4'h0) begin
                n_errors++; $display("FAIL reset_busy got %b want 0000", {busy_a, busy_b, trc_a, trc_b});
            end
        end
    endtask

    task automatic test_round_robin();
        int b, id, bt, ecyc;
        logic [IDW+DW-1:0] e;
        do_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 4; j++)
                pq[i].push_back({j[0], 4'(i), 4'(j)});
        run(14, 64'h0, 64'h0, 64'h0, 1'b0);
        n_checks++;
        if (wqa.size() != 9) begin
            n_errors++; $display("FAIL rr_count got %0d want 9", wqa.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                b = k / 2; id = b % N; bt = (b / N) * 2 + k % 2;
                e = {2'(id), 4'(id), 4'(bt)};
                ecyc = 1 + 3 * b + k % 2;
                n_checks += 2;
                if (wqa[k] !== e) begin
                    n_errors++; $display("FAIL rr_entry%0d got %h want %h", k, wqa[k], e);
                end
                if (wca[k] != ecyc) begin
                    n_errors++; $display("FAIL rr_cycle%0d got %0d want %0d", k, wca[k], ecyc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int ecyc[5] = '{1, 2, 6, 7, 8};
        do_reset();
        for (int j = 0; j < 5; j++)
            pq[2].push_back({(j == 4), 8'hA0 + 8'(j)});
        run(11, 64'h38, 64'h0, 64'h0, 1'b0);
        n_checks += 3;
        if (stl_a !== 16'd3) begin
            n_errors++; $display("FAIL bp_stall got %0d want 3", stl_a);
        end
        if (wfa != 0 || wfb != 0) begin
            n_errors++; $display("FAIL bp_wr_while_full got %0d/%0d want 0", wfa, wfb);
        end
        if (wqa.size() != 5) begin
            n_errors++; $display("FAIL bp_count got %0d want 5", wqa.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks += 2;
                if (wqa[k] !== {2'd2, 8'hA0 + 8'(k)}) begin
                    n_errors++; $display("FAIL bp_entry%0d got %h want %h", k, wqa[k], {2'd2, 8'hA0 + 8'(k)});
                end
                if (wca[k] != ecyc[k]) begin
                    n_errors++; $display("FAIL bp_cycle%0d got %0d want %0d", k, wca[k], ecyc[k]);
                end
            end
        end
    endtask

    task automatic test_forced_release();
        logic [IDW+DW-1:0] e[9] = '{10'h110, 10'h111, 10'h112, 10'h113,
                                    10'h330, 10'h331, 10'h332, 10'h114, 10'h115};
        int ecyc[9] = '{1, 2, 3, 4, 6, 7, 8, 10, 11};
        do_reset();
        for (int j = 0; j < 6; j++) pq[1].push_back({(j == 5), 8'h10 + 8'(j)});
        for (int j = 0; j < 3; j++) pq[3].push_back({(j == 2), 8'h30 + 8'(j)});
        run(14, 64'h0, 64'h0, 64'h0, 1'b1);
        n_checks += 2;
        if (tcb.size() != 1 || tcb[0] != 5) begin
            n_errors++; $display("FAIL fr_trunc got %0d pulses first %0d want 1 at 5", tcb.size(), (tcb.size() > 0) ? tcb[0] : -1);
        end
        if (wqb.size() != 9) begin
            n_errors++; $display("FAIL fr_count got %0d want 9", wqb.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                n_checks += 2;
                if (wqb[k] !== e[k]) begin
                    n_errors++; $display("FAIL fr_entry%0d got %h want %h", k, wqb[k], e[k]);
                end
                if (wcb[k] != ecyc[k]) begin
                    n_errors++; $display("FAIL fr_cycle%0d got %0d want %0d", k, wcb[k], ecyc[k]);
                end
            end
        end
    endtask

    task automatic test_valid_gap();
        logic [IDW+DW-1:0] e[4] = '{10'h000, 10'h001, 10'h002, 10'h111};
        int ecyc[4] = '{1, 2, 8, 10};
        do_reset();
        for (int j = 0; j < 3; j++) pq[0].push_back({(j == 2), 8'(j)});
        pq[1].push_back({1'b1, 8'h11});
        run(12, 64'h0, 64'h0, 64'hF8, 1'b0);
        n_checks += 2;
        if (stl_a !== 16'd0) begin
            n_errors++; $display("FAIL gap_stall got %0d want 0", stl_a);
        end
        if (wqa.size() != 4) begin
            n_errors++; $display("FAIL gap_count got %0d want 4", wqa.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks += 2;
                if (wqa[k] !== e[k]) begin
                    n_errors++; $display("FAIL gap_entry%0d got %h want %h", k, wqa[k], e[k]);
                end
                if (wca[k] != ecyc[k]) begin
                    n_errors++; $display("FAIL gap_cycle%0d got %0d want %0d", k, wca[k], ecyc[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [IDW+DW-1:0] e[5] = '{10'h330, 10'h331, 10'h000, 10'h001, 10'h332};
        int ecyc[5] = '{1, 2, 2, 3, 5};
        do_reset();
        for (int j = 0; j < 4; j++) pq[3].push_back({(j == 3), 8'h30 + 8'(j)});
        run(3, 64'h0, 64'h0, 64'h0, 1'b0);
        pq[0].push_back({1'b0, 8'h00});
        pq[0].push_back({1'b1, 8'h01});
        run(6, 64'h0, 64'h1, 64'h0, 1'b0);
        n_checks++;
        if (wqa.size() != 5) begin
            n_errors++; $display("FAIL rmid_count got %0d want 5", wqa.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks += 2;
                if (wqa[k] !== e[k]) begin
                    n_errors++; $display("FAIL rmid_entry%0d got %h want %h", k, wqa[k], e[k]);
                end
                if (wca[k] != ecyc[k]) begin
                    n_errors++; $display("FAIL rmid_cycle%0d got %0d want %0d", k, wca[k], ecyc[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0]      e_rdy, a_rdy;
        logic              e_wr, a_wr, a_busy, a_trc;
        logic [IDW+DW-1:0] e_din, a_din;
        logic [IDW-1:0]    a_gid;
        logic [15:0]       a_stl;
        int                g;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            resetn = ($urandom_range(99) != 0);
            for (int i = 0; i < N; i++) begin
                vld[i] = ($urandom_range(9) < 7);
                lst[i] = ($urandom_range(9) < 3);
            end
            dat  = $urandom;
            full = ($urandom_range(3) == 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                e_rdy = '0; e_wr = 1'b0; e_din = '0;
                g = m_cur[k];
                if (resetn && g >= 0) begin
                    if (!full) e_rdy[g] = 1'b1;
                    if (vld[g] && !full) begin
                        e_wr  = 1'b1;
                        e_din = {IDW'(g), dat[g*DW +: DW]};
                    end
                end
                a_rdy  = k ? rdy_b  : rdy_a;
                a_wr   = k ? wr_b   : wr_a;
                a_din  = k ? din_b  : din_a;
                a_gid  = k ? gid_b  : gid_a;
                a_busy = k ? busy_b : busy_a;
                a_trc  = k ? trc_b  : trc_a;
                a_stl  = k ? stl_b  : stl_a;
                n_checks += 7;
                if (a_rdy !== e_rdy) begin
                    n_errors++; $display("FAIL rnd_ready dut%0d cyc%0d got %b want %b", k, c, a_rdy, e_rdy);
                end
                if (a_wr !== e_wr) begin
                    n_errors++; $display("FAIL rnd_wr dut%0d cyc%0d got %b want %b", k, c, a_wr, e_wr);
                end
                if (a_din !== e_din) begin
                    n_errors++; $display("FAIL rnd_data dut%0d cyc%0d got %h want %h", k, c, a_din, e_din);
                end
                if (a_gid !== IDW'(m_gid[k])) begin
                    n_errors++; $display("FAIL rnd_grant dut%0d cyc%0d got %0d want %0d", k, c, a_gid, m_gid[k]);
                end
                if (a_busy !== (m_cur[k] >= 0)) begin
                    n_errors++; $display("FAIL rnd_busy dut%0d cyc%0d got %b want %b", k, c, a_busy, (m_cur[k] >= 0));
                end
                if (a_trc !== m_trunc[k]) begin
                    n_errors++; $display("FAIL rnd_trunc dut%0d cyc%0d got %b want %b", k, c, a_trc, m_trunc[k]);
                end
                if (a_stl !== 16'(m_stall[k])) begin
                    n_errors++; $display("FAIL rnd_stall dut%0d cyc%0d got %0d want %0d", k, c, a_stl, m_stall[k]);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_forced_release();
        test_valid_gap();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
